// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and constants for the configurable UART transmitter
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int UART_MIN_DIV = 2;

    // 2'b11 is reserved and behaves as no parity
    function automatic logic par_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with full/empty/level for the UART TX frame queue
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [W-1:0]             i_wr_data,
    input  logic                     i_rd_en,
    output logic [W-1:0]             o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign o_full    = (count == LW'(DEPTH));
    assign o_empty   = (count == '0);
    assign o_level   = count;
    assign o_rd_data = mem[rptr];

    // a simultaneous pop frees the slot, so a push into a full FIFO is legal then
    assign do_rd = i_rd_en && !o_empty;
    assign do_wr = i_wr_en && (!o_full || do_rd);

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + AW'(1);
            end
            if (do_rd) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART TX with runtime parity/stop config and internal baud divider; UART_TX_FIFO_EN adds a TX FIFO
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DIV_W-1:0]              i_baud_div,
    input  logic [1:0]                    i_parity,
    input  logic                          i_stop2,
    output logic                          o_txd,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    logic [2:0]           state;
    logic [DIV_W-1:0]     baud_cnt;
    logic [DIV_W-1:0]     div_q;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_q;
    logic                 par_bit_q;
    logic                 stop2_q;
    logic                 stop_cnt;
    logic                 rst_done;

    logic                 bit_end;
    logic                 last_stop_clk;
    logic                 can_take;
    logic                 take;

    logic                 ld_valid;
    logic [DATA_BITS-1:0] ld_data;
    logic [1:0]           ld_par;
    logic                 ld_stop2;
    logic [DIV_W-1:0]     ld_div;
    logic [DIV_W-1:0]     ld_div_eff;

    assign bit_end       = (baud_cnt == DIV_W'(1));
    assign last_stop_clk = (state == ST_STOP) && bit_end && (!stop2_q || stop_cnt);
    // rst_done keeps ready low for the first cycle after reset release
    assign can_take      = rst_done && ((state == ST_IDLE) || last_stop_clk);
    assign take          = ld_valid && can_take;
    assign ld_div_eff    = (ld_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : ld_div;

`ifdef UART_TX_FIFO_EN
    localparam int FW = DATA_BITS + 2 + 1 + DIV_W;

    logic [FW-1:0] f_rd;
    logic          f_full;
    logic          f_empty;

    assign o_ready = rst_done && !f_full;

    uart_tx_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_valid && o_ready),
        .i_wr_data ({i_data, i_parity, i_stop2, i_baud_div}),
        .i_rd_en   (take),
        .o_rd_data (f_rd),
        .o_full    (f_full),
        .o_empty   (f_empty),
        .o_level   (o_fifo_level)
    );

    assign ld_valid = !f_empty;
    assign {ld_data, ld_par, ld_stop2, ld_div} = f_rd;
`else
    assign o_ready      = can_take;
    assign o_fifo_level = '0;
    assign ld_valid     = i_valid;
    assign ld_data      = i_data;
    assign ld_par       = i_parity;
    assign ld_stop2     = i_stop2;
    assign ld_div       = i_baud_div;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            div_q     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_cnt  <= 1'b0;
            rst_done  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (take) begin
                // the whole frame config is frozen here; later input changes wait for the next frame
                state     <= ST_START;
                baud_cnt  <= ld_div_eff;
                div_q     <= ld_div_eff;
                shreg     <= ld_data;
                par_en_q  <= par_enabled(ld_par);
                par_bit_q <= (ld_par == PAR_ODD) ? ~^ld_data : ^ld_data;
                stop2_q   <= ld_stop2;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (!bit_end) begin
                    baud_cnt <= baud_cnt - DIV_W'(1);
                end else begin
                    baud_cnt <= div_q;
                    case (state)
                        ST_START: state <= ST_DATA;
                        ST_DATA: begin
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                state <= par_en_q ? ST_PARITY : ST_STOP;
                            end
                        end
                        ST_PARITY: state <= ST_STOP;
                        ST_STOP: begin
                            if (stop2_q && !stop_cnt) begin
                                stop_cnt <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        o_txd = 1'b1;
        case (state)
            ST_START:  o_txd = 1'b0;
            ST_DATA:   o_txd = shreg[0];
            ST_PARITY: o_txd = par_bit_q;
            default:   o_txd = 1'b1;
        endcase
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - randomized self-checking bench for uart_tx_cfg against a frame-level line model
module tb_uart_tx_cfg;

    localparam int DB = 8;
    localparam int DW = 16;
    localparam int FD = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [DB-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_baud_div;
    logic [1:0]    i_parity;
    logic          i_stop2;
    logic          o_txd;
    logic          o_busy;
    logic [$clog2(FD):0] o_fifo_level;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_cfg #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_baud_div   (i_baud_div),
        .i_parity     (i_parity),
        .i_stop2      (i_stop2),
        .o_txd        (o_txd),
        .o_busy       (o_busy),
        .o_fifo_level (o_fifo_level)
    );

    logic [DB-1:0] s_data[$];
    logic [1:0]    s_par[$];
    logic          s_stop2[$];
    logic [DW-1:0] s_div[$];
    int            s_gap[$];

    logic c_txd[$], c_busy[$], c_rdy[$];
    logic e_txd[$], e_busy[$], e_rdy[$];
    int   acc_t[$];
    bit   timeout;

    task automatic clear_stim();
        s_data.delete(); s_par.delete(); s_stop2.delete(); s_div.delete(); s_gap.delete();
    endtask

    task automatic add_word(input logic [DB-1:0] d, input logic [1:0] p, input logic st2,
                            input logic [DW-1:0] bd, input int gap);
        s_data.push_back(d); s_par.push_back(p); s_stop2.push_back(st2);
        s_div.push_back(bd); s_gap.push_back(gap);
    endtask

    task automatic scramble_inputs();
        i_data     = DB'($urandom);
        i_parity   = 2'($urandom);
        i_stop2    = 1'($urandom);
        i_baud_div = DW'($urandom_range(0, 9));
    endtask

    // Line model: a frame is a list of bit values, each held max(div,2) clocks, starting the clock after accept
    function automatic void model_frame(input logic [DB-1:0] d, input logic [1:0] p, input logic st2,
                                        input logic [DW-1:0] bd, input int start);
        int   div;
        logic bits[$];
        div = (bd < 2) ? 2 : int'(bd);
        while (e_txd.size() < start) begin
            e_txd.push_back(1'b1); e_busy.push_back(1'b0);
        end
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (p == 2'b01) bits.push_back(^d);
        if (p == 2'b10) bits.push_back(~^d);
        bits.push_back(1'b1);
        if (st2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < div; j++) begin
                e_txd.push_back(bits[k]); e_busy.push_back(1'b1);
            end
        end
    endfunction

    // Drives the stimulus queues and records the line; one sample per negedge, index t
    task automatic run_stream();
        int  w = 0;
        int  t = 0;
        int  gap_left;
        bit  done = 0;
        c_txd.delete(); c_busy.delete(); c_rdy.delete();
        e_txd.delete(); e_busy.delete(); e_rdy.delete(); acc_t.delete();
        timeout  = 0;
        gap_left = (s_gap.size() > 0) ? s_gap[0] : 0;
        while (!done) begin
            @(negedge i_clk);
            c_txd.push_back(o_txd); c_busy.push_back(o_busy); c_rdy.push_back(o_ready);
            e_rdy.push_back(e_txd.size() <= t + 1);
            if (w < s_data.size() && gap_left == 0) begin
                i_data = s_data[w]; i_parity = s_par[w]; i_stop2 = s_stop2[w];
                i_baud_div = s_div[w]; i_valid = 1'b1;
                if (o_ready) begin
                    model_frame(s_data[w], s_par[w], s_stop2[w], s_div[w], t + 1);
                    acc_t.push_back(t);
                    w++;
                    gap_left = (w < s_data.size()) ? s_gap[w] : 0;
                end
            end else begin
                if (gap_left > 0) gap_left--;
                i_valid = 1'b0;
                scramble_inputs();
            end
            t++;
            if (w >= s_data.size() && t >= e_txd.size() + 3) done = 1;
            if (t > 5000) begin
                timeout = 1;
                done    = 1;
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        while (e_txd.size() < c_txd.size()) begin
            e_txd.push_back(1'b1); e_busy.push_back(1'b0);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_baud_div = '0; i_parity = 2'b00; i_stop2 = 1'b0;
        repeat (3) @(negedge i_clk);
        total++; if (o_txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", o_txd); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
        total++; if (o_fifo_level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", o_fifo_level); end
        i_rst_n = 1'b1;
        #1;
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL release_ready_early got=%b exp=0", o_ready); end
        @(negedge i_clk);
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", o_ready); end
        total++; if (o_txd !== 1'b1) begin bad++; $display("FAIL release_txd got=%b exp=1", o_txd); end
    endtask

`ifndef UART_TX_FIFO_EN
    task automatic test_8n1();
        logic [9:0] pat = 10'b1101001010;
        int a;
        int busy_n = 0;
        clear_stim();
        add_word(8'hA5, 2'b00, 1'b0, 16'd4, 0);
        run_stream();
        total++; if (timeout || acc_t.size() != 1) begin bad++; $display("FAIL 8n1_accept got=%0d exp=1", acc_t.size()); end
        for (int t = 0; t < c_txd.size(); t++) begin
            total++;
            if ({c_txd[t], c_busy[t], c_rdy[t]} !== {e_txd[t], e_busy[t], e_rdy[t]}) begin
                bad++; $display("FAIL 8n1_line t=%0d got=%b%b%b exp=%b%b%b", t, c_txd[t], c_busy[t], c_rdy[t], e_txd[t], e_busy[t], e_rdy[t]);
            end
            if (c_busy[t]) busy_n++;
        end
        a = (acc_t.size() > 0) ? acc_t[0] : 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (a + 1 + 4 * k + j >= c_txd.size() || c_txd[a + 1 + 4 * k + j] !== pat[k]) begin
                    bad++; $display("FAIL 8n1_pattern bit=%0d clk=%0d exp=%b", k, j, pat[k]);
                end
            end
        end
        total++; if (busy_n != 40) begin bad++; $display("FAIL 8n1_busy_len got=%0d exp=40", busy_n); end
    endtask

    task automatic test_parity();
        int busy_n = 0;
        int p;
        clear_stim();
        add_word(8'h07, 2'b01, 1'b0, 16'd3, 0);
        add_word(8'h07, 2'b10, 1'b0, 16'd3, 2);
        run_stream();
        total++; if (timeout || acc_t.size() != 2) begin bad++; $display("FAIL parity_accept got=%0d exp=2", acc_t.size()); end
        for (int t = 0; t < c_txd.size(); t++) begin
            total++;
            if ({c_txd[t], c_busy[t], c_rdy[t]} !== {e_txd[t], e_busy[t], e_rdy[t]}) begin
                bad++; $display("FAIL parity_line t=%0d got=%b%b%b exp=%b%b%b", t, c_txd[t], c_busy[t], c_rdy[t], e_txd[t], e_busy[t], e_rdy[t]);
            end
            if (c_busy[t]) busy_n++;
        end
        if (acc_t.size() == 2) begin
            p = acc_t[0] + 1 + 9 * 3;
            total++; if (c_txd[p] !== 1'b1) begin bad++; $display("FAIL parity_even got=%b exp=1", c_txd[p]); end
            p = acc_t[1] + 1 + 9 * 3;
            total++; if (c_txd[p] !== 1'b0) begin bad++; $display("FAIL parity_odd got=%b exp=0", c_txd[p]); end
        end
        total++; if (busy_n != 66) begin bad++; $display("FAIL parity_busy_len got=%0d exp=66", busy_n); end
    endtask

    task automatic test_stop2_b2b();
        int a;
        clear_stim();
        add_word(DB'($urandom), 2'b00, 1'b1, 16'd3, 0);
        add_word(DB'($urandom), 2'b00, 1'b1, 16'd3, 0);
        run_stream();
        total++; if (timeout || acc_t.size() != 2) begin bad++; $display("FAIL b2b_accept got=%0d exp=2", acc_t.size()); end
        for (int t = 0; t < c_txd.size(); t++) begin
            total++;
            if ({c_txd[t], c_busy[t], c_rdy[t]} !== {e_txd[t], e_busy[t], e_rdy[t]}) begin
                bad++; $display("FAIL b2b_line t=%0d got=%b%b%b exp=%b%b%b", t, c_txd[t], c_busy[t], c_rdy[t], e_txd[t], e_busy[t], e_rdy[t]);
            end
        end
        if (acc_t.size() == 2) begin
            a = acc_t[0];
            total++; if (acc_t[1] != a + 33) begin bad++; $display("FAIL b2b_accept_time got=%0d exp=%0d", acc_t[1], a + 33); end
            for (int t = a + 28; t <= a + 33; t++) begin
                total++; if (c_txd[t] !== 1'b1) begin bad++; $display("FAIL b2b_stop t=%0d got=%b exp=1", t, c_txd[t]); end
            end
            total++; if (c_txd[a + 34] !== 1'b0) begin bad++; $display("FAIL b2b_nogap got=%b exp=0", c_txd[a + 34]); end
        end
    endtask

    task automatic test_div_min();
        int busy_n = 0;
        clear_stim();
        add_word(DB'($urandom), 2'b00, 1'b0, 16'd0, 0);
        add_word(DB'($urandom), 2'b11, 1'b0, 16'd1, 3);
        run_stream();
        total++; if (timeout || acc_t.size() != 2) begin bad++; $display("FAIL divmin_accept got=%0d exp=2", acc_t.size()); end
        for (int t = 0; t < c_txd.size(); t++) begin
            total++;
            if ({c_txd[t], c_busy[t], c_rdy[t]} !== {e_txd[t], e_busy[t], e_rdy[t]}) begin
                bad++; $display("FAIL divmin_line t=%0d got=%b%b%b exp=%b%b%b", t, c_txd[t], c_busy[t], c_rdy[t], e_txd[t], e_busy[t], e_rdy[t]);
            end
            if (c_busy[t]) busy_n++;
        end
        total++; if (busy_n != 40) begin bad++; $display("FAIL divmin_busy_len got=%0d exp=40", busy_n); end
    endtask

    task automatic test_reset_midframe();
        logic [DB-1:0] d = DB'($urandom);
        int n = 0;
        @(negedge i_clk);
        i_data = d; i_parity = 2'b00; i_stop2 = 1'b0; i_baud_div = 16'd4; i_valid = 1'b1;
        while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
        total++; if (!o_ready) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", o_ready); end
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (17) @(negedge i_clk);
        total++; if ({o_txd, o_busy} !== {d[3], 1'b1}) begin bad++; $display("FAIL rstmid_bit3 got=%b%b exp=%b1", o_txd, o_busy, d[3]); end
        i_rst_n = 1'b0;
        @(negedge i_clk);
        total++; if ({o_txd, o_busy, o_ready} !== 3'b100) begin bad++; $display("FAIL rstmid_abort got=%b%b%b exp=100", o_txd, o_busy, o_ready); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        total++; if ({o_txd, o_busy, o_ready} !== 3'b101) begin bad++; $display("FAIL rstmid_release got=%b%b%b exp=101", o_txd, o_busy, o_ready); end
    endtask

    task automatic test_random();
        clear_stim();
        for (int i = 0; i < 15; i++) begin
            add_word(DB'($urandom), 2'($urandom), 1'($urandom), DW'($urandom_range(0, 6)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : 0);
        end
        run_stream();
        total++; if (timeout || acc_t.size() != 15) begin bad++; $display("FAIL random_accept got=%0d exp=15", acc_t.size()); end
        for (int t = 0; t < c_txd.size(); t++) begin
            total++;
            if ({c_txd[t], c_busy[t], c_rdy[t]} !== {e_txd[t], e_busy[t], e_rdy[t]}) begin
                bad++; $display("FAIL random_line t=%0d got=%b%b%b exp=%b%b%b", t, c_txd[t], c_busy[t], c_rdy[t], e_txd[t], e_busy[t], e_rdy[t]);
            end
        end
        total++; if (o_fifo_level !== '0) begin bad++; $display("FAIL level_tied got=%0d exp=0", o_fifo_level); end
    endtask
`else
    task automatic test_fifo();
        logic [DB-1:0] sent[$];
        logic [DB-1:0] got[$];
        logic [DB-1:0] v;
        int  w = 0;
        int  t0 = -1;
        int  max_lvl = 0;
        int  i;
        for (int k = 0; k < 5; k++) sent.push_back(DB'($urandom));
        c_txd.delete();
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            c_txd.push_back(o_txd);
            if (int'(o_fifo_level) > max_lvl) max_lvl = int'(o_fifo_level);
            total++;
            if (o_ready !== (o_fifo_level != FD)) begin bad++; $display("FAIL fifo_ready t=%0d got=%b level=%0d", t, o_ready, o_fifo_level); end
            if (w < 5) begin
                i_data = sent[w]; i_parity = 2'b00; i_stop2 = 1'b0; i_baud_div = 16'd2; i_valid = 1'b1;
                if (o_ready) begin
                    if (t0 < 0) t0 = t;
                    w++;
                end
            end else begin
                i_valid = 1'b0;
                scramble_inputs();
            end
        end
        total++; if (max_lvl != FD) begin bad++; $display("FAIL fifo_max_level got=%0d exp=%0d", max_lvl, FD); end
        total++; if (t0 < 0 || c_txd[t0 + 1] !== 1'b1 || c_txd[t0 + 2] !== 1'b0) begin bad++; $display("FAIL fifo_latency t0=%0d", t0); end
        i = 0;
        while (i + 20 <= c_txd.size()) begin
            if (c_txd[i] == 1'b0) begin
                for (int k = 0; k < DB; k++) v[k] = c_txd[i + 2 * (k + 1)];
                got.push_back(v);
                i += 20;
            end else begin
                i++;
            end
        end
        total++; if (got.size() != 5) begin bad++; $display("FAIL fifo_count got=%0d exp=5", got.size()); end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            total++; if (got[k] !== sent[k]) begin bad++; $display("FAIL fifo_order k=%0d got=%h exp=%h", k, got[k], sent[k]); end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`else
        test_8n1();
        test_parity();
        test_stop2_b2b();
        test_div_min();
        test_reset_midframe();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
